ysyx_220053_mem_arbiter: RTL and testbench

YSYX_220053_MEM_ARBITER -- requirements
Module: ysyx_220053_mem_arbiter

---
 rtl/ysyx_220053_arb_pkg.sv | 18 +
 rtl/ysyx_220053_arb_pick.sv | 36 +++
 rtl/ysyx_220053_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_ysyx_220053_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_220053_arb_pkg.sv
// ysyx_220053_arb_pkg
// Shared definitions for the IFU/LSU memory arbiter:
//   arb_state_t      - arbiter FSM states (IDLE, REQ, WAIT, RESP)
//   GNT_IFU/GNT_LSU  - one-bit grant identifiers used for the latched grant
//                      and the round-robin last-grant register
package ysyx_220053_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    localparam logic GNT_IFU = 1'b0;
    localparam logic GNT_LSU = 1'b1;

endpackage

// File: rtl/ysyx_220053_arb_pick.sv
// ysyx_220053_arb_pick
// Combinational winner selection between the IFU and LSU requesters.
//   ifu_valid  in   IFU request pending
//   lsu_valid  in   LSU request pending
//   last_gnt   in   requester granted last (only with YSYX_220053_ARB_RR_EN)
//   gnt_valid  out  at least one requester is pending
//   gnt_id     out  winning requester (GNT_IFU / GNT_LSU)
// Default build: fixed priority, LSU over IFU.
// YSYX_220053_ARB_RR_EN: ties go to the requester that was not granted last.
module ysyx_220053_arb_pick
    import ysyx_220053_arb_pkg::*;
(
    input  logic ifu_valid,
    input  logic lsu_valid,
`ifdef YSYX_220053_ARB_RR_EN
    input  logic last_gnt,
`endif
    output logic gnt_valid,
    output logic gnt_id
);

    always_comb begin
        gnt_valid = ifu_valid | lsu_valid;
        gnt_id    = GNT_IFU;
        if (ifu_valid && lsu_valid) begin
`ifdef YSYX_220053_ARB_RR_EN
            gnt_id = (last_gnt == GNT_LSU) ? GNT_IFU : GNT_LSU;
`else
            gnt_id = GNT_LSU;
`endif
        end else if (lsu_valid) begin
            gnt_id = GNT_LSU;
        end
    end

endmodule

// File: rtl/ysyx_220053_mem_arbiter.sv
// ysyx_220053_mem_arbiter
// Shares one memory port between the instruction fetch unit (IFU) and the
// load/store unit (LSU), with a single transaction in flight at a time.
//   clk, rst                      clock, synchronous active-high reset
//   ifu_req_* / ifu_resp_*        fetch request handshake and read response
//   lsu_req_* / lsu_resp_*        load/store request handshake and response
//                                 (stores also get a one-cycle resp pulse)
//   mem_req_* / mem_resp_*        downstream memory request and response
// FSM: IDLE (arbitrate, accept) -> REQ (present request) -> WAIT (await
// response) -> RESP (one-cycle resp_valid to the granted requester) -> IDLE.
// Optional macro YSYX_220053_ARB_RR_EN switches tie resolution from fixed
// LSU-over-IFU priority to round-robin using a one-bit last-grant register.
module ysyx_220053_mem_arbiter
    import ysyx_220053_arb_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int MASK_W = DATA_W / 8;

    arb_state_t          state;
    logic                gnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   wmask_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                gnt_valid;
    logic                gnt_id;
    logic                handshake;

`ifdef YSYX_220053_ARB_RR_EN
    logic                last_q;
`endif

    ysyx_220053_arb_pick u_pick (
        .ifu_valid (ifu_req_valid),
        .lsu_valid (lsu_req_valid),
`ifdef YSYX_220053_ARB_RR_EN
        .last_gnt  (last_q),
`endif
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Ready is only offered in IDLE and only to the winner; it is masked
    // during reset so nothing looks accepted while the block is clearing.
    assign ifu_req_ready = !rst && (state == IDLE) && gnt_valid && (gnt_id == GNT_IFU);
    assign lsu_req_ready = !rst && (state == IDLE) && gnt_valid && (gnt_id == GNT_LSU);
    assign handshake     = (ifu_req_valid && ifu_req_ready) || (lsu_req_valid && lsu_req_ready);

    assign mem_addr  = addr_q;
    assign mem_wen   = wen_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;

    // Both requesters see the same registered data; only resp_valid tells
    // them whose transaction it was.
    assign ifu_rdata = rdata_q;
    assign lsu_rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            gnt_q          <= GNT_IFU;
            addr_q         <= '0;
            wen_q          <= 1'b0;
            wdata_q        <= '0;
            wmask_q        <= '0;
            rdata_q        <= '0;
            mem_req_valid  <= 1'b0;
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
`ifdef YSYX_220053_ARB_RR_EN
            // Starting from "last = LSU" makes the first tie go to the IFU.
            last_q         <= GNT_LSU;
`endif
        end else begin
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        gnt_q         <= gnt_id;
                        mem_req_valid <= 1'b1;
                        state         <= REQ;
`ifdef YSYX_220053_ARB_RR_EN
                        last_q        <= gnt_id;
`endif
                        if (gnt_id == GNT_LSU) begin
                            addr_q  <= lsu_addr;
                            wen_q   <= lsu_wen;
                            wdata_q <= lsu_wdata;
                            wmask_q <= lsu_wmask;
                        end else begin
                            // Fetches are always full reads.
                            addr_q  <= ifu_addr;
                            wen_q   <= 1'b0;
                            wdata_q <= '0;
                            wmask_q <= '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        rdata_q        <= mem_rdata;
                        ifu_resp_valid <= (gnt_q == GNT_IFU);
                        lsu_resp_valid <= (gnt_q == GNT_LSU);
                        state          <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_220053_mem_arbiter.sv
// Self-checking bench for ysyx_220053_mem_arbiter. Stimulus issues requests
// and drives the memory side; every accepted request pushes its expected
// response into a queue which a negedge monitor pops whenever a resp_valid
// appears. Build with YSYX_220053_ARB_RR_EN to check the round-robin order.
`timescale 1ns/1ps
module tb_ysyx_220053_mem_arbiter;
    import ysyx_220053_arb_pkg::*;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int MASK_W = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ifu_req_valid = 1'b0;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr = '0;
    logic              ifu_resp_valid;
    logic [DATA_W-1:0] ifu_rdata;
    logic              lsu_req_valid = 1'b0;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_addr = '0;
    logic              lsu_wen = 1'b0;
    logic [DATA_W-1:0] lsu_wdata = '0;
    logic [MASK_W-1:0] lsu_wmask = '0;
    logic              lsu_resp_valid;
    logic [DATA_W-1:0] lsu_rdata;
    logic              mem_req_valid;
    logic              mem_req_ready = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_resp_valid = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;

    typedef struct {
        logic              id;
        logic [DATA_W-1:0] data;
        logic              chk_data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    // Grant order for four back-to-back ties after reset, bit i = i-th grant.
`ifdef YSYX_220053_ARB_RR_EN
    logic [3:0] tie_order = 4'b1010;
`else
    logic [3:0] tie_order = 4'b1111;
`endif

    ysyx_220053_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expect_resp(input logic id, input logic [63:0] d, input logic cd);
        exp_t e;
        e.id       = id;
        e.data     = d;
        e.chk_data = cd;
        sb_q.push_back(e);
    endtask

    // Called on the negedge after a handshake; returns on the negedge where
    // the response pulse is visible.
    task automatic mem_serve(input int stall, input logic [63:0] a, input logic w,
                             input logic [7:0] m, input logic [63:0] wd, input logic [63:0] rd);
        int n = 0;
        while (mem_req_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mem_req_seen", 64'(mem_req_valid), 64'd1);
        chk("mem_addr", mem_addr, a);
        chk("mem_wen", 64'(mem_wen), 64'(w));
        chk("mem_wmask", 64'(mem_wmask), 64'(m));
        if (w) chk("mem_wdata", mem_wdata, wd);
        for (int i = 0; i < stall; i++) begin
            mem_req_ready = 1'b0;
            @(negedge clk);
            chk("bp_valid", 64'(mem_req_valid), 64'd1);
            chk("bp_addr", mem_addr, a);
            chk("bp_ready", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = rd;
        @(negedge clk);
        mem_resp_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (ifu_resp_valid || lsu_resp_valid) begin
            chk("resp_both", 64'(ifu_resp_valid & lsu_resp_valid), 64'd0);
            if (sb_q.size() == 0) begin
                chk("resp_unexpected", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("resp_id", 64'(lsu_resp_valid), 64'(mon_e.id));
                if (mon_e.chk_data)
                    chk("resp_data", lsu_resp_valid ? lsu_rdata : ifu_rdata, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic g;
        // Reset, with both requesters pushing: nothing may be accepted.
        rst = 1'b1;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_state", 64'(dut.state), 64'(IDLE));
        chk("rst_ready", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
        chk("rst_mem_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wmask", 64'(mem_wmask), 64'd0);
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_quiet", 64'({ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid}), 64'd0);

        // IFU-only read, minimum latency.
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h0000_0000_8000_0000;
        #1;
        chk("s1_ifu_ready", 64'(ifu_req_ready), 64'd1);
        chk("s1_lsu_ready", 64'(lsu_req_ready), 64'd0);
        expect_resp(GNT_IFU, 64'h0000_0000_0000_0413, 1'b1);
        @(negedge clk);
        ifu_req_valid = 1'b0;
        chk("s1_ready_req", 64'(ifu_req_ready), 64'd0);
        mem_serve(0, 64'h0000_0000_8000_0000, 1'b0, 8'h00, 64'd0, 64'h0000_0000_0000_0413);
        chk("s1_lat_ifu", 64'(ifu_resp_valid), 64'd1);
        chk("s1_lat_lsu", 64'(lsu_resp_valid), 64'd0);
        @(negedge clk);
        chk("s1_idle", 64'(dut.state), 64'(IDLE));
        chk("s1_pulse", 64'(ifu_resp_valid), 64'd0);

        // Simultaneous IFU fetch and LSU store: LSU first, IFU next.
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h0000_0000_8000_0004;
        lsu_req_valid = 1'b1;
        lsu_addr      = 64'h0000_0000_8000_1000;
        lsu_wen       = 1'b1;
        lsu_wdata     = 64'h0000_0000_DEAD_BEEF;
        lsu_wmask     = 8'h0F;
        #1;
        chk("s2_lsu_ready", 64'(lsu_req_ready), 64'd1);
        chk("s2_ifu_ready", 64'(ifu_req_ready), 64'd0);
        expect_resp(GNT_LSU, 64'd0, 1'b0);
        @(negedge clk);
        lsu_req_valid = 1'b0;
        lsu_wen       = 1'b0;
        mem_serve(0, 64'h0000_0000_8000_1000, 1'b1, 8'h0F, 64'h0000_0000_DEAD_BEEF, 64'd0);
        chk("s2_ifu_wait_resp", 64'(ifu_req_ready), 64'd0);
        @(negedge clk);
        chk("s2_ifu_next", 64'(ifu_req_ready), 64'd1);
        expect_resp(GNT_IFU, 64'h0000_0000_00A0_0093, 1'b1);
        @(negedge clk);
        ifu_req_valid = 1'b0;
        mem_serve(0, 64'h0000_0000_8000_0004, 1'b0, 8'h00, 64'd0, 64'h0000_0000_00A0_0093);
        @(negedge clk);

        // Four back-to-back ties right after reset.
        rst = 1'b1;
        @(negedge clk);
        rst           = 1'b0;
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h0000_0000_8000_0008;
        lsu_req_valid = 1'b1;
        lsu_addr      = 64'h0000_0000_8000_2000;
        lsu_wen       = 1'b0;
        lsu_wmask     = 8'h00;
        for (int i = 0; i < 4; i++) begin
            g = tie_order[i];
            #1;
            chk("s3_ifu_ready", 64'(ifu_req_ready), 64'(!g));
            chk("s3_lsu_ready", 64'(lsu_req_ready), 64'(g));
            expect_resp(g, 64'h100 + 64'(i), 1'b1);
            @(negedge clk);
            mem_serve(0, g ? 64'h0000_0000_8000_2000 : 64'h0000_0000_8000_0008,
                      1'b0, 8'h00, 64'd0, 64'h100 + 64'(i));
            @(negedge clk);
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        @(negedge clk);

        // Backpressure: memory not ready for 5 cycles, both requesters pending.
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h0000_0000_8000_0010;
        #1;
        chk("s4_ifu_ready", 64'(ifu_req_ready), 64'd1);
        expect_resp(GNT_IFU, 64'h1111, 1'b1);
        @(negedge clk);
        lsu_req_valid = 1'b1;
        lsu_addr      = 64'h0000_0000_8000_3000;
        mem_serve(5, 64'h0000_0000_8000_0010, 1'b0, 8'h00, 64'd0, 64'h1111);
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        @(negedge clk);

        // Spurious memory handshakes in IDLE and in REQ.
        mem_resp_valid = 1'b1;
        mem_req_ready  = 1'b1;
        @(negedge clk);
        chk("s5_idle_state", 64'(dut.state), 64'(IDLE));
        chk("s5_idle_out", 64'({mem_req_valid, ifu_resp_valid, lsu_resp_valid}), 64'd0);
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b0;
        ifu_req_valid  = 1'b1;
        ifu_addr       = 64'h0000_0000_8000_0020;
        expect_resp(GNT_IFU, 64'h2222, 1'b1);
        @(negedge clk);
        ifu_req_valid  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'hBAD0;
        @(negedge clk);
        chk("s5_req_state", 64'(dut.state), 64'(REQ));
        chk("s5_req_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
        @(negedge clk);
        chk("s5_req_state2", 64'(dut.state), 64'(REQ));
        mem_resp_valid = 1'b0;
        mem_serve(0, 64'h0000_0000_8000_0020, 1'b0, 8'h00, 64'd0, 64'h2222);
        @(negedge clk);

        // Reset while waiting for the memory response.
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h0000_0000_8000_0030;
        @(negedge clk);
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("s6_wait", 64'(dut.state), 64'(WAIT));
        rst = 1'b1;
        @(negedge clk);
        rst            = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h3333;
        chk("s6_rst_idle", 64'(dut.state), 64'(IDLE));
        chk("s6_rst_mem_valid", 64'(mem_req_valid), 64'd0);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk("s6_ignored", 64'(dut.state), 64'(IDLE));
        chk("s6_no_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
        @(negedge clk);
        chk("s6_no_resp2", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h0000_0000_8000_0040;
        #1;
        chk("s6_next_ready", 64'(ifu_req_ready), 64'd1);
        expect_resp(GNT_IFU, 64'h4444, 1'b1);
        @(negedge clk);
        ifu_req_valid = 1'b0;
        mem_serve(0, 64'h0000_0000_8000_0040, 1'b0, 8'h00, 64'd0, 64'h4444);
        repeat (3) @(negedge clk);

        chk("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
